lsu: RTL and testbench

// - Load/store unit between the CPU execute stage and the dmem R/W port of the memory block.
// - Accepts one load or store per valid/ready handshake and sequences the access through the

---
 rtl/lsu.sv | 136 +++++++++++++
 tb/tb_lsu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: sequences one load/store per handshake through a registered-read dmem port.
// Define LSU_MISALIGN_TRAP_EN to fault on misaligned half/word; otherwise addresses are force-aligned.
module lsu #(
    parameter int unsigned MEMSIZE = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_fault,
    output logic        o_mem_write,
    output logic        o_mem_byte,
    output logic        o_mem_hwrd,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [32:0] MemLimit = 33'(MEMSIZE) * 33'd4;

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic        write_q, unsigned_q, fault_q;

    logic        accept, misalign, req_fault;
    logic [31:0] req_addr_eff;
    logic [4:0]  shamt;
    logic [31:0] shifted, load_data;

    assign accept = i_req_valid && (state_q == StIdle);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((i_req_size == 2'b01) && i_req_addr[0]) ||
                      ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00));
    assign req_addr_eff = i_req_addr;
`else
    assign misalign = 1'b0;
    always_comb begin
        req_addr_eff = i_req_addr;
        if (i_req_size == 2'b01) req_addr_eff[0] = 1'b0;
        if (i_req_size == 2'b10) req_addr_eff[1:0] = 2'b00;
    end
`endif

    assign req_fault = (i_req_size == 2'b11) || ({1'b0, i_req_addr} >= MemLimit) || misalign;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q     <= req_addr_eff;
                wdata_q    <= i_req_wdata;
                size_q     <= i_req_size;
                write_q    <= i_req_write;
                unsigned_q <= i_req_unsigned;
                fault_q    <= req_fault;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = req_fault ? StResp : StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Halfword lane selection uses only addr[1]; byte and word use addr[1:0].
    always_comb begin
        shamt   = (size_q == 2'b01) ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
        shifted = i_mem_rdata >> shamt;
        unique case (size_q)
            2'b00:   load_data = unsigned_q ? {24'h0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = unsigned_q ? {16'h0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        o_req_ready = (state_q == StIdle);
        o_rsp_valid = 1'b0;
        o_rsp_fault = 1'b0;
        o_rsp_rdata = '0;
        o_mem_write = 1'b0;
        o_mem_byte  = 1'b0;
        o_mem_hwrd  = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        unique case (state_q)
            StAccess: begin
                o_mem_addr = addr_q;
                if (write_q) begin
                    // Reset during the access cycle must not commit the write.
                    o_mem_write = !i_rst;
                    o_mem_byte  = (size_q == 2'b00);
                    o_mem_hwrd  = (size_q == 2'b01);
                    unique case (size_q)
                        2'b00:   o_mem_wdata = {4{wdata_q[7:0]}};
                        2'b01:   o_mem_wdata = {2{wdata_q[15:0]}};
                        default: o_mem_wdata = wdata_q;
                    endcase
                end
            end
            StResp: begin
                o_rsp_valid = !i_rst;
                o_rsp_fault = fault_q;
                if (!fault_q && !write_q) o_rsp_rdata = load_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a behavioural single-cycle registered-read memory and a
// scoreboard queue of expected responses.
module tb_lsu;

    localparam int unsigned MemWords = 2048;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        mem_write, mem_byte, mem_hwrd;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [MemWords];
    int          mem_write_cnt = 0;
    exp_t        exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;

    logic        acc_write, acc_byte, acc_hwrd;
    logic [31:0] acc_addr, acc_wdata;

    lsu #(.MEMSIZE(MemWords)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_write    (req_write),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_fault    (rsp_fault),
        .o_mem_write    (mem_write),
        .o_mem_byte     (mem_byte),
        .o_mem_hwrd     (mem_hwrd),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: lane writes selected by byte/hwrd flags, registered full-word read.
    always @(posedge clk) begin
        if (mem_write) begin
            mem_write_cnt <= mem_write_cnt + 1;
            if (mem_byte)
                mem[mem_addr[12:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[8*mem_addr[1:0] +: 8];
            else if (mem_hwrd)
                mem[mem_addr[12:2]][16*mem_addr[1] +: 16] <= mem_wdata[16*mem_addr[1] +: 16];
            else
                mem[mem_addr[12:2]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[12:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                          input logic un, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_f, input int exp_lat);
        exp_t e;
        int   lat = 0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = un;
        req_addr     = a;
        req_wdata    = wd;
        exp_q.push_back('{rdata: exp_rd, fault: exp_f, lat: exp_lat});
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 6 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                acc_write = mem_write;
                acc_byte  = mem_byte;
                acc_hwrd  = mem_hwrd;
                acc_addr  = mem_addr;
                acc_wdata = mem_wdata;
            end
            if (rsp_valid) lat = c;
        end
        e = exp_q.pop_front();
        chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
        if (lat != 0) begin
            chk({tag, "_rdata"}, rsp_rdata, e.rdata);
            chk({tag, "_fault"}, {31'b0, rsp_fault}, {31'b0, e.fault});
            @(negedge clk);
            chk({tag, "_pulse"}, {31'b0, rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        int wcnt;
        for (int i = 0; i < int'(MemWords); i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp", {29'b0, rsp_valid, rsp_fault, mem_write}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_flags", {30'b0, mem_byte, mem_hwrd}, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_mwdata", mem_wdata, 32'd0);

        do_req("st_w", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
        chk("st_w_acc", {27'b0, acc_write, acc_byte, acc_hwrd, 2'b0}, 32'h10);
        chk("st_w_addr", acc_addr, 32'h10);
        chk("st_w_wdata", acc_wdata, 32'hDEADBEEF);
        do_req("ld_w", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);
        chk("ld_w_nowr", {31'b0, acc_write}, 32'd0);

        do_req("st_b", 1, 2'b00, 0, 32'h13, 32'hABCDEF80, 32'h0, 0, 2);
        chk("st_b_wdata", acc_wdata, 32'h80808080);
        chk("st_b_flags", {30'b0, acc_byte, acc_hwrd}, 32'd2);
        do_req("ld_bs", 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0, 2);
        do_req("ld_bu", 0, 2'b00, 1, 32'h13, 32'h0, 32'h00000080, 0, 2);
        do_req("ld_w2", 0, 2'b10, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0, 2);
        do_req("ld_bu1", 0, 2'b00, 1, 32'h11, 32'h0, 32'h000000BE, 0, 2);
        do_req("ld_hs0", 0, 2'b01, 0, 32'h10, 32'h0, 32'hFFFFBEEF, 0, 2);
        do_req("ld_hu2", 0, 2'b01, 1, 32'h12, 32'h0, 32'h000080AD, 0, 2);

        do_req("st_h", 1, 2'b01, 0, 32'h22, 32'hFFFF1234, 32'h0, 0, 2);
        chk("st_h_wdata", acc_wdata, 32'h12341234);
        chk("st_h_flags", {30'b0, acc_byte, acc_hwrd}, 32'd1);
        do_req("ld_hs", 0, 2'b01, 0, 32'h22, 32'h0, 32'h00001234, 0, 2);

        do_req("st_1000", 1, 2'b10, 0, 32'h1000, 32'h55AA1234, 32'h0, 0, 2);
        wcnt = mem_write_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("ld_mis", 0, 2'b10, 0, 32'h1002, 32'h0, 32'h0, 1, 1);
        chk("ld_mis_nowr", {31'b0, acc_write}, 32'd0);
`else
        do_req("ld_mis", 0, 2'b10, 0, 32'h1002, 32'h0, 32'h55AA1234, 0, 2);
        chk("ld_mis_addr", acc_addr, 32'h1000);
`endif

        do_req("ld_oob", 0, 2'b10, 0, MemWords * 4, 32'h0, 32'h0, 1, 1);
        do_req("ld_sz3", 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 1);
        do_req("st_oob", 1, 2'b10, 0, MemWords * 4, 32'h12345678, 32'h0, 1, 1);
        do_req("st_sz3", 1, 2'b11, 0, 32'h10, 32'h12345678, 32'h0, 1, 1);
        chk("fault_nowr", 32'(mem_write_cnt), 32'(wcnt));

        // Reset asserted during the access cycle of a store.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h40;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_acc_wr", {31'b0, mem_write}, 32'd0);
        chk("rst_acc_rsp", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_acc_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_acc_rsp2", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rst_acc_rsp3", {31'b0, rsp_valid}, 32'd0);
        chk("rst_acc_cnt", 32'(mem_write_cnt), 32'(wcnt));
        do_req("ld_rst", 0, 2'b10, 0, 32'h40, 32'h0, 32'h0, 0, 2);
        do_req("ld_after", 0, 2'b10, 0, 32'h20, 32'h0, 32'h12340000, 0, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
